// File: rtl/pcie_tx_axis_arb_pkg.sv
// Shared types and helpers for the PCIe TX AXI-S packet arbiter.
package pcie_tx_axis_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } t_tx_arb_state;

    // Wraps idx into [0, n) when idx is known to be below 2*n.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/pcie_tx_axis_arb_if.sv
// Multi-source TX AXI-S bundle plus the merged output stream towards the CDC bridge.
interface pcie_tx_axis_arb_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 512,
    parameter int USER_W    = 10
);
    localparam int IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]          in_tvalid;
    logic [NUM_PORTS-1:0]          in_tready;
    logic [NUM_PORTS*DATA_W-1:0]   in_tdata;
    logic [NUM_PORTS*DATA_W/8-1:0] in_tkeep;
    logic [NUM_PORTS-1:0]          in_tlast;
    logic [NUM_PORTS*USER_W-1:0]   in_tuser;

    logic                          out_tvalid;
    logic                          out_tready;
    logic [DATA_W-1:0]             out_tdata;
    logic [DATA_W/8-1:0]           out_tkeep;
    logic                          out_tlast;
    logic [USER_W-1:0]             out_tuser;
    logic [IDX_W-1:0]              out_src;

    // Arbiter view: sinks the sources, drives the merged stream.
    modport slave (
        input  in_tvalid, in_tdata, in_tkeep, in_tlast, in_tuser, out_tready,
        output in_tready, out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser, out_src
    );

    // Environment view: the TX sources and the downstream bridge.
    modport master (
        output in_tvalid, in_tdata, in_tkeep, in_tlast, in_tuser, out_tready,
        input  in_tready, out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser, out_src
    );

endinterface

// File: rtl/pcie_tx_axis_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr_i, wrapping.
module pcie_tx_axis_arb_rr_arbiter
    import pcie_tx_axis_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the closest requester to ptr_i wins last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = IDX_W'(rr_wrap(int'(ptr_i) + k, NUM_PORTS));
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_tx_axis_arb.sv
// Packet-level round-robin merge of NUM_PORTS PCIe TX AXI-S sources into one
// registered stream; a granted source keeps the output until its tlast.
module pcie_tx_axis_arb
    import pcie_tx_axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 512,
    parameter int USER_W    = 10,
    parameter int MAX_BEATS = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pcie_tx_axis_arb_if.slave        axis,
    output logic                     err_long
);

    localparam int IDX_W  = $clog2(NUM_PORTS);
    localparam int KEEP_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_BEATS + 1);

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [KEEP_W-1:0] tkeep;
        logic              tlast;
        logic [USER_W-1:0] tuser;
    } t_tx_beat;

    t_tx_arb_state        state_q;
    logic [IDX_W-1:0]     grant_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [CNT_W-1:0]     beat_cnt_q;
    logic                 err_long_q;
    logic                 out_vld_q;
    logic [IDX_W-1:0]     out_src_q;
    t_tx_beat             out_beat_q;

    logic                 load_ok;
    logic                 arb_any;
    logic [NUM_PORTS-1:0] arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic [IDX_W-1:0]     sel;
    logic [NUM_PORTS-1:0] ready_vec;
    logic                 accept;
    logic                 acc_last;
    t_tx_beat             sel_beat;

    pcie_tx_axis_arb_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .req_i (axis.in_tvalid),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign load_ok = ~out_vld_q | axis.out_tready;

    // Ready never looks at the granted port's own valid beyond the IDLE pick;
    // rst_n gating keeps every ready low while reset is held.
    always_comb begin
        ready_vec = '0;
        sel       = grant_q;
        if (state_q == IDLE) begin
            sel       = arb_idx;
            ready_vec = arb_any ? arb_gnt : '0;
        end else begin
            ready_vec[grant_q] = 1'b1;
        end
        ready_vec = ready_vec & {NUM_PORTS{load_ok & rst_n}};
    end

    assign accept   = |(axis.in_tvalid & ready_vec);
    assign acc_last = axis.in_tlast[sel];

    always_comb begin
        sel_beat.tdata = axis.in_tdata[int'(sel)*DATA_W +: DATA_W];
        sel_beat.tkeep = axis.in_tkeep[int'(sel)*KEEP_W +: KEEP_W];
        sel_beat.tlast = acc_last;
        sel_beat.tuser = axis.in_tuser[int'(sel)*USER_W +: USER_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_long_q <= 1'b0;
            out_vld_q  <= 1'b0;
            out_src_q  <= '0;
        end else begin
            if (load_ok) begin
                out_vld_q <= accept;
            end
            if (accept) begin
                out_src_q <= sel;
                if (beat_cnt_q == CNT_W'(MAX_BEATS)) begin
                    err_long_q <= 1'b1;
                end
                if (acc_last) begin
                    // Finished source drops to lowest priority for the next pick.
                    state_q    <= IDLE;
                    rr_ptr_q   <= IDX_W'(rr_wrap(int'(sel) + 1, NUM_PORTS));
                    beat_cnt_q <= '0;
                end else begin
                    state_q <= LOCKED;
                    grant_q <= sel;
                    if (beat_cnt_q != CNT_W'(MAX_BEATS)) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    // Payload register: only meaningful while out_vld_q is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            out_beat_q <= sel_beat;
        end
    end

    assign axis.in_tready  = ready_vec;
    assign axis.out_tvalid = out_vld_q;
    assign axis.out_tdata  = out_beat_q.tdata;
    assign axis.out_tkeep  = out_beat_q.tkeep;
    assign axis.out_tlast  = out_beat_q.tlast;
    assign axis.out_tuser  = out_beat_q.tuser;
    assign axis.out_src    = out_src_q;
    assign err_long        = err_long_q;

endmodule
